gerenciador_rolhas: RTL

Cork-stock manager for the bottling line. Tracks the corks available to the sealing station (0–99), decrements on every sealing pulse from the main production FSM, accepts manual operator increments, and runs a four-phase refill handshake with the cork dispenser when stock falls below a threshold. It sits downstream of the main FSM, consuming its sealing events. It sits upstream of the display multiplexer and the alarm logic, feeding them BCD digits and a `sem_rolha` flag.

---
 rtl/rolhas_pkg.sv | 7 +
 rtl/bin_para_bcd.sv | 15 +
 rtl/gerenciador_rolhas.sv | 98 +++++++++
 3 files changed

// File: rtl/rolhas_pkg.sv
// rolhas_pkg: shared types and constants for the cork-stock manager.
package rolhas_pkg;
    typedef enum logic [1:0] {OCIOSO, PEDINDO, CARREGANDO, ESPERA} estado_t;
    localparam int ROLHAS_MAX = 99;
    localparam int CONT_W = 7;
    localparam int BCD_W = 4;
endpackage

// File: rtl/bin_para_bcd.sv
// bin_para_bcd: combinational 0..99 binary to two BCD digits.
module bin_para_bcd
    import rolhas_pkg::*;
(
    input  logic [CONT_W-1:0] i_bin,
    output logic [BCD_W-1:0]  o_dez,
    output logic [BCD_W-1:0]  o_uni
);
    always_comb begin
        o_dez = '0;
        for (int d = 1; d <= 9; d++)
            if (i_bin >= CONT_W'(10 * d)) o_dez = BCD_W'(d);
    end
    assign o_uni = BCD_W'(i_bin - CONT_W'(o_dez) * CONT_W'(10));
endmodule

// File: rtl/gerenciador_rolhas.sv
// gerenciador_rolhas: saturating cork counter with BCD outputs and a
// four-phase refill handshake towards the cork dispenser.
module gerenciador_rolhas
    import rolhas_pkg::*;
#(
    parameter int LIMIAR_REPOSICAO = 5,
    parameter int LOTE_REPOSICAO   = 15,
    parameter int TIMEOUT_ACK      = 255,
    parameter int CARGA_INICIAL    = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             vedar,
    input  logic             incrementar,
    input  logic             auto_repor,
    input  logic             repor_ok,
    output logic             repor_req,
    output logic [BCD_W-1:0] rolhas_dezenas,
    output logic [BCD_W-1:0] rolhas_unidades,
    output logic             sem_rolha,
    output logic             vedar_erro,
    output logic             falha_reposicao
);
    localparam int SW = CONT_W + 1;
    localparam int TW = $clog2(TIMEOUT_ACK + 1);
    localparam int LW = $clog2(LOTE_REPOSICAO + 1);

    estado_t           r_estado, w_prox;
    logic [CONT_W-1:0] r_cont, w_cont_prox, w_cont_bcd;
    logic [SW-1:0]     w_soma, w_liq;
    logic [TW-1:0]     r_timer;
    logic [LW-1:0]     r_lote;
    logic [BCD_W-1:0]  w_dez, w_uni, r_dez, r_uni;
    logic              w_carga, w_erro, w_timeout, w_falha_set;
    logic              r_req, r_erro, r_falha, r_sem;

    // Additions are summed first so that vedar+incrementar at zero nets to 0.
    assign w_carga     = r_estado == CARREGANDO;
    assign w_soma      = {1'b0, r_cont} + SW'(incrementar) + SW'(w_carga);
    assign w_erro      = vedar && w_soma == '0;
    assign w_liq       = (vedar && !w_erro) ? w_soma - 1'b1 : w_soma;
    assign w_cont_prox = w_liq > SW'(ROLHAS_MAX) ? CONT_W'(ROLHAS_MAX) : w_liq[CONT_W-1:0];
    assign w_timeout   = r_timer == TW'(TIMEOUT_ACK - 1);
    assign w_falha_set = r_estado == PEDINDO && !repor_ok && w_timeout;

    // Digits track the next count so they change together with it.
    assign w_cont_bcd = reset ? CONT_W'(CARGA_INICIAL) : w_cont_prox;

    bin_para_bcd u_bcd (
        .i_bin(w_cont_bcd),
        .o_dez(w_dez),
        .o_uni(w_uni)
    );

    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            OCIOSO:     if (auto_repor && !r_falha && r_cont < CONT_W'(LIMIAR_REPOSICAO)) w_prox = PEDINDO;
            PEDINDO:    w_prox = repor_ok ? CARREGANDO : (w_timeout || !auto_repor) ? OCIOSO : PEDINDO;
            CARREGANDO: if (r_lote == LW'(LOTE_REPOSICAO - 1) || w_cont_prox == CONT_W'(ROLHAS_MAX)) w_prox = ESPERA;
            ESPERA:     if (!repor_ok) w_prox = OCIOSO;
            default:    w_prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado <= OCIOSO;
            r_cont   <= CONT_W'(CARGA_INICIAL);
            r_timer  <= '0;
            r_lote   <= '0;
            r_req    <= 1'b0;
            r_erro   <= 1'b0;
            r_falha  <= 1'b0;
        end else begin
            r_estado <= w_prox;
            r_cont   <= w_cont_prox;
            r_timer  <= r_estado == PEDINDO ? r_timer + 1'b1 : '0;
            r_lote   <= r_estado == CARREGANDO ? r_lote + 1'b1 : '0;
            r_req    <= w_prox == PEDINDO || w_prox == CARREGANDO;
            r_erro   <= w_erro;
            r_falha  <= r_falha | w_falha_set;
        end
    end

    always_ff @(posedge clock) begin
        r_dez <= w_dez;
        r_uni <= w_uni;
        r_sem <= w_cont_bcd == '0;
    end

    assign repor_req       = r_req;
    assign rolhas_dezenas  = r_dez;
    assign rolhas_unidades = r_uni;
    assign sem_rolha       = r_sem;
    assign vedar_erro      = r_erro;
    assign falha_reposicao = r_falha;
endmodule
